// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared widths, FSM encoding and entry layout for the instruction prefetch buffer.
package instr_prefetch_buffer_pkg;

    localparam int PF_ADDR_W = 14;
    localparam int PF_DATA_W = 16;
    localparam int PF_DEPTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } pf_state_e;

    typedef struct packed {
        logic [PF_ADDR_W-1:0] addr;
        logic [PF_DATA_W-1:0] data;
    } pf_entry_t;

endpackage

// File: rtl/instr_prefetch_buffer_pf_fifo.sv
// Small synchronous FIFO with flush; the head entry is visible combinationally.
module instr_prefetch_buffer_pf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 30
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_pop_ok;
    logic w_push_ok;

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign w_pop_ok  = i_pop & (r_count != '0);
    assign w_push_ok = i_push & ((r_count != FULL_CNT) | w_pop_ok);

    // Pointer and occupancy bookkeeping; flush returns to the empty state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: FIFO of {addr,data}, zero-latency hits,
// flush-and-restart on non-sequential fetches, never withdraws a memory request.
module instr_prefetch_buffer
    import instr_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH  = PF_DEPTH,
    parameter int ADDR_W = PF_ADDR_W,
    parameter int DATA_W = PF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic [ADDR_W-1:0] core_addr,
    output logic [DATA_W-1:0] core_data,
    output logic              core_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    pf_state_e         r_state;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_pf_addr;

    logic [ADDR_W+DATA_W-1:0] w_head;
    logic [ADDR_W-1:0]        w_head_addr;
    logic [DATA_W-1:0]        w_head_data;
    logic [CNT_W-1:0]         w_count;
    logic                     w_empty;
    logic [ADDR_W-1:0]        w_expected;
    logic                     w_hit;
    logic                     w_miss_wait;
    logic                     w_redirect;
    logic                     w_issue;
    logic                     w_push;

    assign w_head_addr = w_head[ADDR_W+DATA_W-1:DATA_W];
    assign w_head_data = w_head[DATA_W-1:0];
    assign w_empty     = (w_count == '0);

    // While a request is outstanding, the core waiting on exactly that address is not a redirect.
    assign w_expected  = (r_state != ST_IDLE) ? r_mem_addr : r_pf_addr;
    assign w_hit       = core_req & ~w_empty & (w_head_addr == core_addr);
    assign w_miss_wait = core_req & w_empty & (core_addr == w_expected);
    assign w_redirect  = core_req & ~w_hit & ~w_miss_wait;

    // Only IDLE issues, so the outstanding-request slot reservation term is zero here.
    assign w_issue = (r_state == ST_IDLE) & (w_count < FULL_CNT) & ~w_redirect;
    assign w_push  = (r_state == ST_BUSY) & mem_ack & ~w_redirect;

    instr_prefetch_buffer_pf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_pf_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .i_push      (w_push),
        .i_push_data ({r_mem_addr, mem_rdata}),
        .i_pop       (w_hit),
        .i_flush     (w_redirect),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // Memory-side FSM: issue, wait for ack, or drain a stale request after a redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_pf_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_redirect) begin
                        r_pf_addr <= core_addr;
                    end else if (w_issue) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pf_addr;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                        r_pf_addr <= w_redirect ? core_addr : r_pf_addr + 1'b1;
                    end else if (w_redirect) begin
                        r_state   <= ST_DRAIN;
                        r_pf_addr <= core_addr;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                    if (w_redirect) r_pf_addr <= core_addr;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign core_valid = w_hit;
    assign core_data  = w_head_data;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed plus randomized bench for instr_prefetch_buffer, checked against a
// transaction-level queue model of the prefetcher and a latency-programmable memory.
module tb_instr_prefetch_buffer;
    import instr_prefetch_buffer_pkg::*;

    localparam int AW    = 14;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_data;
    logic          core_valid;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    instr_prefetch_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_addr  (core_addr),
        .core_data  (core_data),
        .core_valid (core_valid),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    logic [DW-1:0] mem_arr [1<<AW];
    int checks = 0;
    int errors = 0;

    // Reference model: expected FIFO contents, next prefetch address, outstanding request.
    pf_entry_t     q[$];
    logic [AW-1:0] m_pf;
    logic [AW-1:0] m_maddr;
    bit            m_inflight;
    bit            m_discard;

    int            lat = 1;
    int            rsp_cnt = 0;
    bit            prev_req = 1'b0;
    int            issue_cnt = 0;
    int            dut_hits = 0;
    bit            last_hit = 1'b0;
    logic [AW-1:0] c_next;
    logic [AW-1:0] maddr_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        maddr_log.delete();
        m_pf       = '0;
        m_maddr    = '0;
        m_inflight = 1'b0;
        m_discard  = 1'b0;
        rsp_cnt    = 0;
        prev_req   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        core_req  = 1'b0;
        core_addr = '0;
        mem_ack   = 1'b0;
        model_reset();
        #1;
        chk("rst_mem_req",    32'(mem_req),    32'd0);
        chk("rst_mem_addr",   32'(mem_addr),   32'd0);
        chk("rst_core_valid", 32'(core_valid), 32'd0);
        chk("rst_core_data",  32'(core_data),  32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // One clock: memory responder, drive core, check outputs, advance the model.
    task automatic step(input bit creq, input logic [AW-1:0] caddr, input bit fack);
        bit            ack;
        bit            hit;
        bit            missw;
        bit            redir;
        bit            issue;
        logic [AW-1:0] exp_a;
        pf_entry_t     e;
        @(negedge clk);
        ack = 1'b0;
        if (mem_req === 1'b1) begin
            rsp_cnt++;
            if (rsp_cnt >= lat) begin
                ack     = 1'b1;
                rsp_cnt = 0;
            end
        end else begin
            rsp_cnt = 0;
        end
        if (fack) ack = 1'b1;
        if (mem_req === 1'b1 && !prev_req) begin
            issue_cnt++;
            maddr_log.push_back(mem_addr);
        end
        prev_req  = (mem_req === 1'b1);
        core_req  = creq;
        core_addr = caddr;
        mem_ack   = ack;
        mem_rdata = ack ? mem_arr[mem_addr] : DW'($urandom);
        #1;
        hit   = creq && q.size() != 0 && q[0].addr == caddr;
        exp_a = m_inflight ? m_maddr : m_pf;
        missw = creq && q.size() == 0 && caddr == exp_a;
        redir = creq && !hit && !missw;
        if (core_valid === 1'b1) dut_hits++;
        chk("core_valid", 32'(core_valid), 32'(hit));
        if (hit) chk("core_data", 32'(core_data), 32'(q[0].data));
        chk("mem_req", 32'(mem_req), 32'(m_inflight));
        if (m_inflight) chk("mem_addr", 32'(mem_addr), 32'(m_maddr));
        issue = !m_inflight && q.size() < DEPTH && !redir;
        if (hit) void'(q.pop_front());
        if (redir) q.delete();
        if (m_inflight && ack) begin
            if (!m_discard && !redir) begin
                e.addr = m_maddr;
                e.data = mem_arr[m_maddr];
                q.push_back(e);
                m_pf = m_pf + 1'b1;
            end
            m_inflight = 1'b0;
            m_discard  = 1'b0;
        end else if (m_inflight && redir) begin
            m_discard = 1'b1;
        end else if (issue) begin
            m_inflight = 1'b1;
            m_maddr    = m_pf;
        end
        if (redir) m_pf = caddr;
        last_hit = hit;
    endtask

    task automatic follow(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, c_next, 1'b0);
            if (last_hit) c_next = c_next + 1'b1;
        end
    endtask

    initial begin
        bit            got;
        int            r;
        logic [AW-1:0] tgt;
        for (int i = 0; i < (1 << AW); i++) mem_arr[i] = DW'($urandom);
        reset     = 1'b0;
        core_req  = 1'b0;
        core_addr = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // Sequential stream, single-cycle memory
        lat = 1;
        do_reset();
        c_next   = '0;
        dut_hits = 0;
        follow(24);
        chk("seq_hits_ge8", 32'(dut_hits >= 8), 32'd1);
        chk("seq_first_addr", 32'(maddr_log[0]), 32'h0000);
        chk("seq_third_addr", 32'(maddr_log[2]), 32'h0002);

        // Core stalls: FIFO fills to DEPTH and issuing stops
        do_reset();
        issue_cnt = 0;
        repeat (20) step(1'b0, '0, 1'b0);
        chk("stall_issues", 32'(issue_cnt), 32'(DEPTH));
        chk("stall_last_addr", 32'(maddr_log[DEPTH-1]), 32'(DEPTH-1));
        step(1'b0, '0, 1'b1);
        c_next = '0;
        follow(12);

        // Redirect while a request is outstanding
        lat = 3;
        do_reset();
        step(1'b1, 14'h0005, 1'b0);
        step(1'b1, 14'h0005, 1'b0);
        step(1'b1, 14'h0005, 1'b0);
        step(1'b1, 14'h0100, 1'b0);
        c_next = 14'h0100;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b1, c_next, 1'b0);
            if (core_valid === 1'b1 && core_addr == 14'h0100) got = 1'b1;
            if (last_hit) c_next = c_next + 1'b1;
        end
        chk("redir_hit_0100", 32'(got), 32'd1);

        // Redirect in the same cycle as the ack
        lat = 1;
        do_reset();
        step(1'b0, '0, 1'b0);
        step(1'b1, 14'h0200, 1'b0);
        step(1'b1, 14'h0200, 1'b0);
        chk("ack_redir_idle", 32'(mem_req), 32'd0);
        step(1'b1, 14'h0200, 1'b0);
        chk("ack_redir_next", 32'(mem_addr), 32'h0200);
        c_next = 14'h0200;
        follow(6);

        // Address wrap is sequential
        do_reset();
        c_next = 14'h3FFE;
        follow(14);
        chk("wrap_a0", 32'(maddr_log[0]), 32'h3FFE);
        chk("wrap_a1", 32'(maddr_log[1]), 32'h3FFF);
        chk("wrap_a2", 32'(maddr_log[2]), 32'h0000);
        chk("wrap_a3", 32'(maddr_log[3]), 32'h0001);

        // Asynchronous reset while BUSY with two entries buffered
        lat = 2;
        do_reset();
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step(1'b0, '0, 1'b0);
            if (q.size() == 2 && m_inflight) got = 1'b1;
        end
        chk("async_setup", 32'(got), 32'd1);
        @(posedge clk);
        #2;
        core_req  = 1'b1;
        core_addr = '0;
        mem_ack   = 1'b0;
        #1;
        chk("async_pre_valid", 32'(core_valid), 32'd1);
        chk("async_pre_req",   32'(mem_req),    32'd1);
        reset = 1'b0;
        #1;
        chk("async_mem_req",    32'(mem_req),    32'd0);
        chk("async_core_valid", 32'(core_valid), 32'd0);
        model_reset();
        core_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) step(1'b0, '0, 1'b0);
        chk("async_restart_addr", 32'(maddr_log[0]), 32'h0000);

        // Randomized mix of following, stalls, redirects and stray acks
        c_next = '0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 15);
            if (r == 0) begin
                lat = $urandom_range(1, 4);
                follow(1);
            end else if (r == 1) begin
                tgt = ($urandom_range(0, 3) == 0) ? AW'(14'h3FFC + AW'($urandom_range(0, 3)))
                                                   : AW'($urandom);
                c_next = tgt;
                step(1'b1, tgt, 1'b0);
                if (last_hit) c_next = c_next + 1'b1;
            end else if (r <= 4) begin
                step(1'b0, AW'($urandom), 1'b0);
            end else if (r == 5) begin
                step(1'b1, c_next, 1'b1);
                if (last_hit) c_next = c_next + 1'b1;
            end else begin
                follow(1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
